midi_writer: RTL
================

// Module: midi_writer
// PURPOSE
// - MIDI transmitter: serializes one MIDI message per handshake onto a 31250-baud UART line (8N1, LSB first).
// - Counterpart of midi_reader; its status/data inputs mirror midi_reader outputs, so reader output loops back to writer input.
// - Used for MIDI-thru/echo and as the loopback stimulus source for reader tests. Single clock domain (clk_in, 100 MHz).
// PARAMETERS
// - CLK_FREQ        100_000_000  clk_in frequency, Hz
// - BAUD            31_250       MIDI bit rate; CYCLES_PER_BIT = CLK_FREQ/BAUD (3200 at defaults), integer
// - RUNNING_STATUS  1            1: omit status byte when it equals the last transmitted channel status; 0: always send it
// PORTS
// - clk_in          input   1   system clock
// - rst_in          input   1   synchronous reset, active high
// - status_in       input   4   message-type nibble (8 off, 9 on, A poly AT, B CC, C prog, D chan AT, E bend, F system)
// - channel_in      input   4   low nibble of status byte (channel; for F = system sub-code)
// - data_byte1_in   input   8   first data byte (bit 7 forced to 0 on send)
// - data_byte2_in   input   8   second data byte (bit 7 forced to 0 on send)
// - valid_in        input   1   message present
// - ready_out       output  1   writer idle, can accept
// - tx_wire_out     output  1   UART line, idle high
// - busy_out        output  1   frame in progress (= ~ready_out)
// - msg_done_out    output  1   1-cycle pulse, last stop bit of message complete
// BEHAVIOUR
// - Reset: tx_wire_out=1, ready_out=1, busy_out=0, msg_done_out=0, FSM=IDLE, stored running status invalid. Reset mid-frame
//   aborts immediately: line high on the cycle after rst_in sampled, message discarded, running status invalidated.
// - Handshake: accept when valid_in && ready_out at a clock edge; all inputs latched that edge; ready_out low from next cycle.
//   valid_in while ready_out=0 is ignored (no queue). Inputs need not hold after acceptance.
// - Length: status 8,9,A,B,E -> status+2 data; C,D -> status+1 data; F -> status byte {F,channel_in} only.
//   status_in < 8 is invalid: dropped, ready_out stays 1, no line activity, no msg_done_out.
// - Running status (RUNNING_STATUS=1): for 8..E, if {status_in,channel_in} equals stored valid status, skip status byte;
//   otherwise send it and store it. F0..F7 invalidate stored status; F8..FF (real-time) leave it untouched.
// - FSM: IDLE -> START (line 0) -> DATA (8 bits, LSB first) -> STOP (line 1) -> START of next byte, or IDLE after last byte.
//   Each bit held exactly CYCLES_PER_BIT cycles via counter 0..CYCLES_PER_BIT-1; 3-bit bit index; 2-bit byte index.
// - Timing: tx_wire_out registered; start bit of first byte begins the cycle after acceptance. Bytes back to back, no idle gap.
//   Message of N bytes occupies exactly N*10*CYCLES_PER_BIT cycles of line time.
// - On the final cycle of the last stop bit: msg_done_out pulses; next cycle ready_out=1 and FSM=IDLE. A new valid_in in
//   that next cycle is accepted, giving a continuous stream (stop bit immediately followed by start bit).
// - tx_wire_out is glitch-free: changes only at bit boundaries.
// TESTING
// - Note-on 9/0, 3C, 64 after reset -> bytes 90 3C 64; 30 bits, each 3200 cycles; msg_done_out 96000 cycles after accept.
// - Second note-on 9/0, 40, 7F (RUNNING_STATUS=1) -> only 40 7F sent (64000 cycles); with RUNNING_STATUS=0 -> 90 40 7F.
// - Program change C/2, 05, dbyte2=AA -> C2 05 only; then note-on 9/2 -> status 92 re-sent (status changed).
// - Real-time F/8 between two 9/0 note-ons -> F8 alone, then second note-on omits 90; F/0 instead -> 90 re-sent.
// - status_in=3, valid_in=1 -> ready_out stays 1, tx_wire_out stays 1 for 10000 cycles, no msg_done_out.
// - rst_in at cycle 5000 of a 3-byte message -> tx_wire_out=1 next cycle, ready_out=1; next note-on 9/0 sends 90 again.
// - valid_in pulses during busy -> ignored; loopback tx_wire_out->midi_reader rx returns identical status/data bytes.

Source files
------------

// File: rtl/midi_writer.sv
// MIDI transmitter: one message per valid/ready handshake, sent as 8N1 UART frames (LSB first),
// with optional running-status suppression of a repeated channel status byte.
module midi_writer #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 31_250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       msg_done_out
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CPB - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [1:0]      byte_idx_r;
  logic [1:0]      last_idx_r;
  logic [7:0]      shift_r;
  logic [7:0]      b1_r;
  logic [7:0]      b2_r;
  logic            tx_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;
  logic            rs_valid_r;
  logic [7:0]      rs_r;

  logic [7:0] status_byte_s;
  logic [7:0] d1_s;
  logic [7:0] d2_s;
  logic       msg_ok_s;
  logic       is_sys_s;
  logic       rs_hit_s;
  logic [1:0] ndata_s;
  logic [7:0] first_s;
  logic [7:0] next1_s;
  logic [7:0] next2_s;
  logic [1:0] last_s;

  assign ready_out    = ready_r;
  assign tx_wire_out  = tx_r;
  assign busy_out     = busy_r;
  assign msg_done_out = done_r;

  // Byte list for the incoming message, with the status byte dropped on a running-status hit
  always_comb begin
    status_byte_s = {status_in, channel_in};
    d1_s          = data_byte1_in & 8'h7F;
    d2_s          = data_byte2_in & 8'h7F;
    msg_ok_s      = status_in[3];
    is_sys_s      = (status_in == 4'hF);
    rs_hit_s      = (RUNNING_STATUS != 0) && rs_valid_r && !is_sys_s && (status_byte_s == rs_r);
    case (status_in)
      4'hC, 4'hD: ndata_s = 2'd1;
      4'hF:       ndata_s = 2'd0;
      default:    ndata_s = 2'd2;
    endcase
    if (rs_hit_s) begin
      first_s = d1_s;
      next1_s = d2_s;
      next2_s = d2_s;
      last_s  = ndata_s - 2'd1;
    end else begin
      first_s = status_byte_s;
      next1_s = d1_s;
      next2_s = d2_s;
      last_s  = ndata_s;
    end
  end

  // Transmit FSM: start/data/stop bits per byte, bytes back to back
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      last_idx_r <= 2'd0;
      shift_r    <= 8'h00;
      b1_r       <= 8'h00;
      b2_r       <= 8'h00;
      tx_r       <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rs_valid_r <= 1'b0;
      rs_r       <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_in && msg_ok_s) begin
            state_r    <= START;
            cnt_r      <= '0;
            byte_idx_r <= 2'd0;
            last_idx_r <= last_s;
            shift_r    <= first_s;
            b1_r       <= next1_s;
            b2_r       <= next2_s;
            tx_r       <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            if (!is_sys_s) begin
              rs_r       <= status_byte_s;
              rs_valid_r <= 1'b1;
            end else if (!channel_in[3]) begin
              // System common/exclusive cancels running status; real-time does not
              rs_valid_r <= 1'b0;
            end
          end
        end
        START: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= '0;
            state_r   <= DATA;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[1];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (byte_idx_r == last_idx_r) begin
              state_r <= IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              byte_idx_r <= byte_idx_r + 2'd1;
              case (byte_idx_r)
                2'd0:    shift_r <= b1_r;
                default: shift_r <= b2_r;
              endcase
              tx_r    <= 1'b0;
              state_r <= START;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
            // Raised one cycle early so the pulse covers the final stop-bit cycle
            if ((cnt_r == CNT_PRE) && (byte_idx_r == last_idx_r)) begin
              done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
